// File: rtl/feature_arbiter_pkg.sv
// Shared definitions for the two-station feature arbiter: authorization codes,
// FSM states and the permission/feature helpers.
package feature_arbiter_pkg;

  typedef enum logic [2:0] {
    AUTH_NONE  = 3'd0,
    AUTH_GUEST = 3'd1,
    AUTH_USER  = 3'd2,
    AUTH_TEST  = 3'd3,
    AUTH_ADMIN = 3'd4
  } auth_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int unsigned NUM_FEAT = 7;

  // Highest feature code an auth level may select; 0 means nothing is allowed.
  function automatic logic [2:0] auth_limit(input logic [2:0] auth);
    case (auth)
      AUTH_GUEST: return 3'd2;
      AUTH_USER:  return 3'd4;
      AUTH_TEST:  return 3'd6;
      AUTH_ADMIN: return 3'd7;
      default:    return 3'd0;
    endcase
  endfunction

  function automatic logic [NUM_FEAT-1:0] fsel_onehot(input logic [2:0] fsel);
    logic [NUM_FEAT-1:0] v;
    v = '0;
    if (fsel != 3'd0) v = NUM_FEAT'(1) << (fsel - 3'd1);
    return v;
  endfunction

endpackage

// File: rtl/feature_arbiter_req_capture.sv
// Per-station request front end: button edge detect, request latch, pending
// flag, permission check and single-cycle deny pulse.
module req_capture
  import feature_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [2:0] auth,
  input  logic [2:0] fsel,
  input  logic       clr,
  output logic       valid,
  output logic       deny,
  output logic [2:0] auth_q,
  output logic [2:0] fsel_q
);

  logic req_q;
  logic pending;
  logic permit;

  assign permit = (fsel_q != 3'd0) && (fsel_q <= auth_limit(auth_q));
  assign valid  = pending && permit;

  // req_q resets high so a button still held through reset is not seen as a new press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q   <= 1'b1;
      pending <= 1'b0;
      deny    <= 1'b0;
      auth_q  <= '0;
      fsel_q  <= '0;
    end else begin
      req_q <= req;
      deny  <= pending && !permit;
      if (pending) begin
        if (clr || !permit) pending <= 1'b0;
      end else if (req && !req_q) begin
        pending <= 1'b1;
        auth_q  <= auth;
        fsel_q  <= fsel;
      end
    end
  end

endmodule

// File: rtl/feature_arbiter.sv
// Grants the shared feature engine to one of two stations by auth priority with
// round-robin tie-break, holding each grant for a bounded time followed by a gap.
module feature_arbiter
  import feature_arbiter_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned GAP_CYCLES  = 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                REQ0,
  input  logic [2:0]          AUTH0,
  input  logic [2:0]          FSEL0,
  input  logic                REQ1,
  input  logic [2:0]          AUTH1,
  input  logic [2:0]          FSEL1,
  output logic                GNT0,
  output logic                GNT1,
  output logic [NUM_FEAT-1:0] FEAT_EN,
  output logic                DENY0,
  output logic                DENY1,
  output logic                BUSY
);

  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  logic       valid0, valid1;
  logic [2:0] auth_q0, auth_q1, fsel_q0, fsel_q1;
  logic [1:0] clr;

  state_t              state, state_nxt;
  logic [HW-1:0]       hold_cnt, hold_nxt;
  logic [GW-1:0]       gap_cnt, gap_nxt;
  logic                holder, holder_nxt;
  logic                last, last_nxt;
  logic                win;
  logic                holder_req;
  logic [1:0]          gnt_q, gnt_nxt;
  logic [NUM_FEAT-1:0] feat_q, feat_nxt;

  req_capture u_cap0 (
    .clk    (CLK),
    .rst    (RST),
    .req    (REQ0),
    .auth   (AUTH0),
    .fsel   (FSEL0),
    .clr    (clr[0]),
    .valid  (valid0),
    .deny   (DENY0),
    .auth_q (auth_q0),
    .fsel_q (fsel_q0)
  );

  req_capture u_cap1 (
    .clk    (CLK),
    .rst    (RST),
    .req    (REQ1),
    .auth   (AUTH1),
    .fsel   (FSEL1),
    .clr    (clr[1]),
    .valid  (valid1),
    .deny   (DENY1),
    .auth_q (auth_q1),
    .fsel_q (fsel_q1)
  );

  assign holder_req = holder ? REQ1 : REQ0;

  always_comb begin
    state_nxt  = state;
    hold_nxt   = hold_cnt;
    gap_nxt    = gap_cnt;
    holder_nxt = holder;
    last_nxt   = last;
    clr        = '0;
    gnt_nxt    = '0;
    feat_nxt   = '0;
    win        = 1'b0;

    // Only valid requests are compared, so raw auth codes order correctly.
    if (valid0 && valid1) begin
      if (auth_q0 > auth_q1)      win = 1'b0;
      else if (auth_q1 > auth_q0) win = 1'b1;
      else                        win = ~last;
    end else begin
      win = valid1;
    end

    case (state)
      ST_IDLE: begin
        if (valid0 || valid1) begin
          state_nxt     = ST_GRANT;
          holder_nxt    = win;
          hold_nxt      = '0;
          clr[win]      = 1'b1;
          gnt_nxt[win]  = 1'b1;
          feat_nxt      = fsel_onehot(win ? fsel_q1 : fsel_q0);
        end
      end
      ST_GRANT: begin
        if ((hold_cnt == HW'(HOLD_CYCLES - 1)) || !holder_req) begin
          state_nxt = ST_GAP;
          gap_nxt   = '0;
        end else begin
          hold_nxt        = hold_cnt + 1'b1;
          gnt_nxt[holder] = 1'b1;
          feat_nxt        = feat_q;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
          state_nxt = ST_IDLE;
          last_nxt  = holder;
        end else begin
          gap_nxt = gap_cnt + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
      gap_cnt  <= '0;
      holder   <= 1'b0;
      last     <= 1'b1;
      gnt_q    <= '0;
      feat_q   <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      gap_cnt  <= gap_nxt;
      holder   <= holder_nxt;
      last     <= last_nxt;
      gnt_q    <= gnt_nxt;
      feat_q   <= feat_nxt;
    end
  end

  assign GNT0    = gnt_q[0];
  assign GNT1    = gnt_q[1];
  assign FEAT_EN = feat_q;
  assign BUSY    = (state != ST_IDLE);

endmodule
